gps_prn_sched: RTL and testbench
================================

# gps_prn_sched

Round-robin scheduler that shares the single `gps` code-generator core between `NREQ` requesters, each asking for the codes of one satellite vehicle (SV/PRN). It replaces the fixed SV number and the software-driven `genNext` bit with a sequenced handshake: select SV, pulse generate, await `codes_valid`, capture, return the result tagged with requester index. It sits between the `gps` core and the Wishbone/DMA front ends that want codes.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `SETUP_CYC`, 2: cycles `core_sv_num_o` is held stable before the generate pulse (1..15).
- `TIMEOUT`, 4096: max cycles waiting for `codes_valid` (only with `GPS_SCHED_TIMEOUT_EN`).

- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: asynchronous active-high reset.
- `req_i` in NREQ: per-requester request level; held until its `ack_o`.
- `req_sv_i` in 6*NREQ: SV number for requester k at bits [6k+5:6k].
- `ack_o` out NREQ: one-cycle pulse, request k accepted.
- `res_valid_o` out 1: result available.
- `res_ready_i` in 1: consumer accepts result.
- `res_id_o` out 3: requester index of result.
- `res_sv_o` out 6: SV number of result.
- `res_err_o` out 1: illegal SV or timeout; code fields are zero.
- `res_ca_o` out 13, `res_p_o` out 128, `res_l_o` out 128: captured codes.
- `core_sv_num_o` out 6: SV number to core.
- `core_gen_next_o` out 1: generate strobe to core.
- `core_ca_i` in 13, `core_p_i` in 128, `core_l_i` in 128, `core_valid_i` in 1: core outputs.

## Operation
- States: IDLE, SETUP, PULSE, WAIT, OUT.
- IDLE: if any `req_i`, grant the first set bit at or after `rr_ptr` (wrapping). Latch index and SV, pulse `ack_o[k]`, set `rr_ptr = k+1 mod NREQ`.
  - SV in 1..37: load `core_sv_num_o` and go to SETUP.
  - SV 0 or >37: go straight to OUT with `res_err_o=1` and zero codes; the core is untouched.
- SETUP: count `SETUP_CYC` cycles, then PULSE.
- PULSE: `core_gen_next_o=1` for exactly this one cycle, then WAIT.
- WAIT: track `core_valid_i` with a registered previous value. On a rising edge (prev 0, now 1), capture the core codes and go to OUT.
  - A `core_valid_i` that was already high at PULSE does not count; a fresh 0→1 transition is required.
- OUT: `res_*` are stable while `res_valid_o=1`. When `res_valid_o & res_ready_i`, go to IDLE. Arbitration resumes the following cycle.
- Requests dropped before `ack_o` are simply not granted. A request that arrives while the scheduler is busy waits; there is no queue.
- `core_sv_num_o` keeps its last value outside SETUP..WAIT.
- Reset (asynchronous, any state):
  - state IDLE, `rr_ptr=0`;
  - all outputs 0, including `core_sv_num_o` and the `res_*` fields;
  - an in-flight generate is abandoned and `core_gen_next_o` drops immediately.

## Timing
- Request seen in IDLE at cycle t: `ack_o` and the new `core_sv_num_o` appear at t+1.
- `core_gen_next_o` is high at t+1+`SETUP_CYC`.
- Rising edge of `core_valid_i` sampled at cycle w: `res_valid_o` is high from w+1.
- Illegal SV: `res_valid_o=1` at t+1, in the same cycle as `ack_o`.
- Minimum spacing between consecutive grants: OUT handshake cycle + 1 IDLE cycle.
- All outputs are registered; there is no combinational path from `req_i` or `res_ready_i`.

## Configuration
- `GPS_SCHED_TIMEOUT_EN` defined: a WAIT cycle counter is present. When it reaches `TIMEOUT` with no rising edge, go to OUT with `res_err_o=1`, zero codes, and `res_sv_o` = the granted SV.
- Macro undefined: WAIT lasts indefinitely, no counter is built, and `res_err_o` is raised only for an illegal SV.

## Structure
- Shared package `gps_sched_pkg`: state encoding (IDLE..OUT), `SV_MIN=1`, `SV_MAX=37`, `SV_W=6`, `CA_W=13`, `PL_W=128`.
- One sub-module, `gps_rr_arb`: purely combinational round-robin arbiter.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt`, binary index, `any`.
  - The FSM and the capture registers stay in `gps_prn_sched`.

## Test plan
- Single request: req0 with SV 12 and `SETUP_CYC=2`. Expect:
  - `ack_o[0]` at t+1, `core_gen_next_o` at t+3;
  - the model raises valid after 5 cycles; `res_valid_o` the next cycle with `res_id_o=0`, `res_sv_o=12`, codes equal to the model and `res_err_o=0`.
- Fairness: all four requesters held high with SVs 1, 2, 3, 4. Expect grants in order 0, 1, 2, 3, 0, and `res_sv_o` in matching order.
- Illegal SV: req2 with SV 0, then SV 40. Expect `res_err_o=1` one cycle after each grant, zero codes, and `core_gen_next_o` never asserted.
- Back-pressure and stale valid: `core_valid_i` held high before PULSE, drops, then rises. Expect:
  - capture only on the new rising edge;
  - `res_ready_i` held low 10 cycles: `res_*` stable and no new `ack_o`.
- Reset mid-WAIT: assert `wb_rst_i` asynchronously. Expect all outputs 0 with no clock edge; after release, req1 with SV 5 completes normally with `ack_o[1]`.
- Timeout (`GPS_SCHED_TIMEOUT_EN`, `TIMEOUT=16`): the core never asserts valid. Expect `res_valid_o` with `res_err_o=1` exactly 17 cycles after PULSE.

Source files
------------

// File: rtl/gps_sched_pkg.sv
// Shared types and constants for the gps PRN scheduler.
// State encoding, SV legality range and code field widths.
package gps_sched_pkg;

    localparam int SV_MIN = 1;
    localparam int SV_MAX = 37;
    localparam int SV_W   = 6;
    localparam int CA_W   = 13;
    localparam int PL_W   = 128;
    localparam int ID_W   = 3;
    localparam int SCNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } sched_state_t;

    function automatic logic sv_legal(input logic [SV_W-1:0] sv);
        return (int'(sv) >= SV_MIN) && (int'(sv) <= SV_MAX);
    endfunction

endpackage

// File: rtl/gps_prn_sched_if.sv
// Requester/result handshake bundle of the gps PRN scheduler.
// slave = scheduler side, master = requesters and result consumer.
interface gps_prn_sched_if #(
    parameter int NREQ = 4
) ();
    import gps_sched_pkg::*;

    logic [NREQ-1:0]      req_i;
    logic [SV_W*NREQ-1:0] req_sv_i;
    logic [NREQ-1:0]      ack_o;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [ID_W-1:0]      res_id_o;
    logic [SV_W-1:0]      res_sv_o;
    logic                 res_err_o;
    logic [CA_W-1:0]      res_ca_o;
    logic [PL_W-1:0]      res_p_o;
    logic [PL_W-1:0]      res_l_o;

    modport slave (
        input  req_i, req_sv_i, res_ready_i,
        output ack_o, res_valid_o, res_id_o, res_sv_o,
        output res_err_o, res_ca_o, res_p_o, res_l_o
    );

    modport master (
        output req_i, req_sv_i, res_ready_i,
        input  ack_o, res_valid_o, res_id_o, res_sv_o,
        input  res_err_o, res_ca_o, res_p_o, res_l_o
    );

endinterface

// File: rtl/gps_rr_arb.sv
// Combinational round-robin arbiter: first request at or after ptr.
// Produces one-hot grant, binary index and an any-request flag.
module gps_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan requesters starting at ptr, wrapping, keep the first hit
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/gps_prn_sched.sv
// Round-robin sharing of one gps code generator between NREQ requesters.
// Optional WAIT timeout is built only when GPS_SCHED_TIMEOUT_EN is defined.
module gps_prn_sched
    import gps_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int SETUP_CYC = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    gps_prn_sched_if.slave   bus,
    output logic [SV_W-1:0]  core_sv_num_o,
    output logic             core_gen_next_o,
    input  logic [CA_W-1:0]  core_ca_i,
    input  logic [PL_W-1:0]  core_p_i,
    input  logic [PL_W-1:0]  core_l_i,
    input  logic             core_valid_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    if (NREQ < 2 || NREQ > 8 || SETUP_CYC < 1 ||
        SETUP_CYC > 15 || TIMEOUT < 1) begin : g_bad_cfg
        $error("gps_prn_sched: parameter out of range");
    end

    sched_state_t state_q, state_d;

    logic [IW-1:0]     rr_ptr_q;
    logic [SCNT_W-1:0] setup_cnt_q;
    logic              valid_prev_q;

    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic [SV_W-1:0]   arb_sv;
    logic              sv_ok;
    logic [IW-1:0]     rr_next;
    logic              valid_rise;
    logic              timeout_hit;

    logic              grant, capture, abort;
    logic [NREQ-1:0]   ack_d;
    logic              gen_d, rvalid_d;

    logic [NREQ-1:0]   ack_q;
    logic              gen_q, rvalid_q;
    logic [SV_W-1:0]   core_sv_q;
    logic [ID_W-1:0]   res_id_q;
    logic [SV_W-1:0]   res_sv_q;
    logic              res_err_q;
    logic [CA_W-1:0]   res_ca_q;
    logic [PL_W-1:0]   res_p_q;
    logic [PL_W-1:0]   res_l_q;

    gps_rr_arb #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .req (bus.req_i),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign arb_sv     = bus.req_sv_i[SV_W*int'(arb_idx) +: SV_W];
    assign sv_ok      = sv_legal(arb_sv);
    assign rr_next    = (arb_idx == LAST) ? '0 : arb_idx + 1'b1;
    assign valid_rise = core_valid_i & ~valid_prev_q;

`ifdef GPS_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt_q;

    // Count cycles spent in WAIT; cleared on every other state
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) wait_cnt_q <= '0;
        else if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
        else wait_cnt_q <= '0;
    end

    assign timeout_hit = (state_q == ST_WAIT) &&
                         (wait_cnt_q == TO_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    // Next-state: grant, hold SV, strobe, await fresh valid, hand off
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) state_d = sv_ok ? ST_SETUP : ST_OUT;
            end
            ST_SETUP: begin
                if (setup_cnt_q == SCNT_W'(SETUP_CYC - 1))
                    state_d = ST_PULSE;
            end
            ST_PULSE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (valid_rise || timeout_hit) state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.res_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs and load strobes
    always_comb begin
        grant    = (state_q == ST_IDLE) && arb_any;
        capture  = (state_q == ST_WAIT) && valid_rise;
        abort    = (state_q == ST_WAIT) && !valid_rise && timeout_hit;
        ack_d    = grant ? arb_gnt : '0;
        gen_d    = (state_d == ST_PULSE);
        rvalid_d = (state_d == ST_OUT);
    end

    // SETUP dwell counter and previous core_valid for edge detection
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            setup_cnt_q  <= '0;
            valid_prev_q <= 1'b0;
        end else begin
            valid_prev_q <= core_valid_i;
            if (state_q == ST_SETUP) setup_cnt_q <= setup_cnt_q + 1'b1;
            else setup_cnt_q <= '0;
        end
    end

    // Output registers, grant latch and code capture
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q     <= '0;
            gen_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rr_ptr_q  <= '0;
            core_sv_q <= '0;
            res_id_q  <= '0;
            res_sv_q  <= '0;
            res_err_q <= 1'b0;
            res_ca_q  <= '0;
            res_p_q   <= '0;
            res_l_q   <= '0;
        end else begin
            ack_q    <= ack_d;
            gen_q    <= gen_d;
            rvalid_q <= rvalid_d;
            if (grant) begin
                rr_ptr_q  <= rr_next;
                res_id_q  <= ID_W'(arb_idx);
                res_sv_q  <= arb_sv;
                res_err_q <= ~sv_ok;
                res_ca_q  <= '0;
                res_p_q   <= '0;
                res_l_q   <= '0;
                if (sv_ok) core_sv_q <= arb_sv;
            end
            if (capture) begin
                res_ca_q  <= core_ca_i;
                res_p_q   <= core_p_i;
                res_l_q   <= core_l_i;
                res_err_q <= 1'b0;
            end
            if (abort) res_err_q <= 1'b1;
        end
    end

    assign bus.ack_o       = ack_q;
    assign bus.res_valid_o = rvalid_q;
    assign bus.res_id_o    = res_id_q;
    assign bus.res_sv_o    = res_sv_q;
    assign bus.res_err_o   = res_err_q;
    assign bus.res_ca_o    = res_ca_q;
    assign bus.res_p_o     = res_p_q;
    assign bus.res_l_o     = res_l_q;
    assign core_sv_num_o   = core_sv_q;
    assign core_gen_next_o = gen_q;

endmodule

// File: tb/tb_gps_prn_sched.sv
// Self-checking bench for gps_prn_sched with a behavioural core model.
// Define GPS_SCHED_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_gps_prn_sched;
    import gps_sched_pkg::*;

    localparam int NREQ      = 4;
    localparam int SETUP_CYC = 2;
    localparam int TIMEOUT   = 16;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i;
    logic [5:0]   core_sv_num_o;
    logic         core_gen_next_o;
    logic [12:0]  core_ca_i;
    logic [127:0] core_p_i;
    logic [127:0] core_l_i;
    logic         core_valid_i;

    int vec  = 0;
    int errs = 0;
    int gen_cnt = 0;
    int mptr = 0;
    logic [5:0] sv_tab [NREQ];

    gps_prn_sched_if #(.NREQ(NREQ)) bus ();

    gps_prn_sched #(
        .NREQ      (NREQ),
        .SETUP_CYC (SETUP_CYC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .bus             (bus),
        .core_sv_num_o   (core_sv_num_o),
        .core_gen_next_o (core_gen_next_o),
        .core_ca_i       (core_ca_i),
        .core_p_i        (core_p_i),
        .core_l_i        (core_l_i),
        .core_valid_i    (core_valid_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Count cycles in which the generate strobe is high
    always @(posedge wb_clk_i) begin
        if (core_gen_next_o === 1'b1) gen_cnt <= gen_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge wb_clk_i);
    endtask

    // Reference arbitration: first pending requester at or after mptr
    function automatic int model_pick(input logic [NREQ-1:0] m);
        for (int i = 0; i < NREQ; i++)
            if (m[(mptr + i) % NREQ]) return (mptr + i) % NREQ;
        return -1;
    endfunction

    function automatic bit model_legal(input logic [5:0] sv);
        return (sv >= 6'd1) && (sv <= 6'd37);
    endfunction

    task automatic set_req(input int j, input logic [5:0] sv);
        sv_tab[j] = sv;
        bus.req_sv_i[6*j +: 6] = sv;
        bus.req_i[j] = 1'b1;
    endtask

    // One complete transaction for requester k, starting from an IDLE DUT
    task automatic txn(input int k, input logic [5:0] sv, input int dly,
                       input int hold, input bit stale,
                       input logic [NREQ-1:0] drop,
                       input logic [NREQ-1:0] late);
        logic [12:0]  ca;
        logic [127:0] p, l;
        logic [278:0] exp_res, got;
        int n;
        ca = 13'($urandom);
        p  = {$urandom, $urandom, $urandom, $urandom};
        l  = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        do begin tick(); n++; end
        while (bus.ack_o === '0 && n < 64);
        vec++;
        if (n != 1 || bus.ack_o !== NREQ'(1 << k)) begin
            errs++;
            $display("FAIL grant: ack_o=%b after %0d cyc, expected %b after 1",
                     bus.ack_o, n, NREQ'(1 << k));
        end
        mptr = (k + 1) % NREQ;
        bus.req_i = bus.req_i & ~drop;
        if (model_legal(sv)) begin
            vec++;
            if (core_sv_num_o !== sv) begin
                errs++;
                $display("FAIL core_sv: got %0d expected %0d", core_sv_num_o, sv);
            end
            if (stale) begin
                core_valid_i = 1'b1;
                core_ca_i = ~ca;
                core_p_i  = ~p;
                core_l_i  = ~l;
            end
            for (int i = 1; i < SETUP_CYC; i++) begin
                tick();
                vec++;
                if (core_gen_next_o !== 1'b0) begin
                    errs++;
                    $display("FAIL gen_early: gen_next=%b in setup expected 0",
                             core_gen_next_o);
                end
            end
            tick();
            vec++;
            if (core_gen_next_o !== 1'b1) begin
                errs++;
                $display("FAIL gen_pulse: gen_next=%b expected 1", core_gen_next_o);
            end
            for (int i = 1; i <= dly; i++) begin
                tick();
                vec++;
                if (core_gen_next_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
                    errs++;
                    $display("FAIL wait_quiet: gen=%b res_valid=%b expected 0 0",
                             core_gen_next_o, bus.res_valid_o);
                end
                if (stale && i == 2) core_valid_i = 1'b0;
            end
            core_valid_i = 1'b1;
            core_ca_i = ca;
            core_p_i  = p;
            core_l_i  = l;
            tick();
            exp_res = {3'(k), sv, 1'b0, ca, p, l};
        end else begin
            exp_res = {3'(k), sv, 1'b1, 13'd0, 128'd0, 128'd0};
        end
        got = {bus.res_id_o, bus.res_sv_o, bus.res_err_o,
               bus.res_ca_o, bus.res_p_o, bus.res_l_o};
        vec++;
        if (bus.res_valid_o !== 1'b1 || got !== exp_res) begin
            errs++;
            $display("FAIL result: valid=%b id=%0d sv=%0d err=%b ca=%h, expected 1 %0d %0d %b %h",
                     bus.res_valid_o, bus.res_id_o, bus.res_sv_o, bus.res_err_o,
                     bus.res_ca_o, k, sv, exp_res[256], exp_res[268:256]);
        end
        core_valid_i = 1'b0;
        bus.req_i = bus.req_i | late;
        for (int h = 0; h < hold; h++) begin
            tick();
            got = {bus.res_id_o, bus.res_sv_o, bus.res_err_o,
                   bus.res_ca_o, bus.res_p_o, bus.res_l_o};
            vec++;
            if (bus.res_valid_o !== 1'b1 || got !== exp_res || bus.ack_o !== '0) begin
                errs++;
                $display("FAIL backpressure: valid=%b ack=%b stable=%b, expected 1 0 1",
                         bus.res_valid_o, bus.ack_o, got === exp_res);
            end
        end
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
        vec++;
        if (bus.res_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL release: res_valid=%b after handshake expected 0",
                     bus.res_valid_o);
        end
    endtask

    task automatic test_reset();
        logic [290:0] z;
        wb_rst_i = 1'b1;
        tick();
        tick();
        z = {bus.ack_o, bus.res_valid_o, bus.res_id_o, bus.res_sv_o,
             bus.res_err_o, bus.res_ca_o, bus.res_p_o, bus.res_l_o,
             core_sv_num_o, core_gen_next_o};
        vec++;
        if (z !== '0) begin
            errs++;
            $display("FAIL reset_state: outputs=%h expected all zero", z);
        end
        wb_rst_i = 1'b0;
        mptr = 0;
        tick();
    endtask

    task automatic test_fairness();
        for (int j = 0; j < NREQ; j++) set_req(j, 6'(j + 1));
        for (int r = 0; r < 5; r++)
            txn(r % NREQ, sv_tab[r % NREQ], $urandom_range(1, 6),
                $urandom_range(0, 3), 1'b0,
                (r == 4) ? 4'b1111 : 4'b0000, 4'b0000);
    endtask

    task automatic test_single();
        set_req(0, 6'd12);
        txn(0, 6'd12, 5, 0, 1'b0, 4'b0001, 4'b0000);
    endtask

    task automatic test_illegal_sv();
        int g0;
        g0 = gen_cnt;
        set_req(2, 6'd0);
        txn(2, 6'd0, 0, 1, 1'b0, 4'b0100, 4'b0000);
        set_req(2, 6'd40);
        txn(2, 6'd40, 0, 2, 1'b0, 4'b0100, 4'b0000);
        vec++;
        if (gen_cnt !== g0) begin
            errs++;
            $display("FAIL illegal_no_gen: gen pulses=%0d expected 0", gen_cnt - g0);
        end
    endtask

    task automatic test_back_to_back_stale();
        logic [5:0] sv;
        sv = 6'($urandom_range(1, 37));
        set_req(3, sv);
        sv_tab[0] = 6'($urandom_range(1, 37));
        bus.req_sv_i[5:0] = sv_tab[0];
        txn(3, sv, 6, 10, 1'b1, 4'b1000, 4'b0001);
        txn(0, sv_tab[0], 3, 0, 1'b0, 4'b0001, 4'b0000);
    endtask

    task automatic test_random();
        int k;
        bit st;
        for (int r = 0; r < 24; r++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!bus.req_i[j] && $urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 5) == 0)
                        set_req(j, ($urandom_range(0, 1) == 1) ? 6'd0
                                   : 6'($urandom_range(38, 63)));
                    else
                        set_req(j, 6'($urandom_range(1, 37)));
                end
            end
            if (bus.req_i == '0) set_req(r % NREQ, 6'($urandom_range(1, 37)));
            k  = model_pick(bus.req_i);
            st = ($urandom_range(0, 3) == 0);
            txn(k, sv_tab[k], st ? $urandom_range(3, 8) : $urandom_range(1, 8),
                $urandom_range(0, 3), st, NREQ'(1 << k), 4'b0000);
        end
        bus.req_i = '0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        logic [290:0] z;
        int n;
        set_req(2, 6'd20);
        n = 0;
        do begin tick(); n++; end
        while (bus.ack_o === '0 && n < 64);
        vec++;
        if (n != 1 || bus.ack_o !== 4'b0100) begin
            errs++;
            $display("FAIL rst_pre_grant: ack_o=%b after %0d expected 0100 after 1",
                     bus.ack_o, n);
        end
        bus.req_i = '0;
        repeat (SETUP_CYC + 2) tick();
        #2 wb_rst_i = 1'b1;
        #1;
        z = {bus.ack_o, bus.res_valid_o, bus.res_id_o, bus.res_sv_o,
             bus.res_err_o, bus.res_ca_o, bus.res_p_o, bus.res_l_o,
             core_sv_num_o, core_gen_next_o};
        vec++;
        if (z !== '0) begin
            errs++;
            $display("FAIL async_reset: outputs=%h expected all zero", z);
        end
        tick();
        wb_rst_i = 1'b0;
        mptr = 0;
        set_req(1, 6'd5);
        set_req(3, 6'd33);
        txn(1, 6'd5, 4, 0, 1'b0, 4'b1010, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            vec++;
            if (bus.ack_o !== '0) begin
                errs++;
                $display("FAIL dropped_req: ack_o=%b expected 0000", bus.ack_o);
            end
        end
    endtask

`ifdef GPS_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        logic [278:0] got, exp_res;
        int n;
        set_req(1, 6'd9);
        n = 0;
        do begin tick(); n++; end
        while (bus.ack_o === '0 && n < 64);
        bus.req_i = '0;
        mptr = 2;
        n = 0;
        while (core_gen_next_o !== 1'b1 && n < 64) begin tick(); n++; end
        n = 0;
        do begin tick(); n++; end
        while (bus.res_valid_o !== 1'b1 && n < 64);
        exp_res = {3'd1, 6'd9, 1'b1, 13'd0, 128'd0, 128'd0};
        got = {bus.res_id_o, bus.res_sv_o, bus.res_err_o,
               bus.res_ca_o, bus.res_p_o, bus.res_l_o};
        vec++;
        if (n != TIMEOUT + 1 || got !== exp_res) begin
            errs++;
            $display("FAIL timeout: valid after %0d cyc err=%b sv=%0d, expected %0d 1 9",
                     n, bus.res_err_o, bus.res_sv_o, TIMEOUT + 1);
        end
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
    endtask
`endif

    initial begin
        bus.req_i       = '0;
        bus.req_sv_i    = '0;
        bus.res_ready_i = 1'b0;
        core_valid_i    = 1'b0;
        core_ca_i       = '0;
        core_p_i        = '0;
        core_l_i        = '0;
        for (int j = 0; j < NREQ; j++) sv_tab[j] = '0;
        test_reset();
        test_fairness();
        test_single();
        test_illegal_sv();
        test_back_to_back_stale();
        test_random();
        test_reset_mid_wait();
`ifdef GPS_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
